// File: rtl/spi_device_tx_serializer.sv
// SPI device transmit path: byte FIFO from the register side, MSB-first mode-0
// serializer driven by oversampled host SCK/CSB, with underflow and byte-done strobes.
module spi_device_tx_serializer #(
    parameter int         FifoDepth   = 8,
    parameter logic [7:0] DefaultByte = 8'hFF,
    parameter int         SyncStages  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [7:0]                     tx_data_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,
    input  logic                           flush_i,
    output logic [$clog2(FifoDepth+1)-1:0] fifo_depth_o,
    input  logic                           sck_i,
    input  logic                           csb_i,
    output logic                           sdo_o,
    output logic                           sdo_en_o,
    output logic                           byte_done_o,
    output logic                           txunderflow_o
);

    localparam int              PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int              CntW      = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);
    localparam logic [0:0]      StIdle    = 1'b0;
    localparam logic [0:0]      StShift   = 1'b1;

    logic [7:0]            r_mem [FifoDepth];
    logic [PtrW-1:0]       r_wptr;
    logic [PtrW-1:0]       r_rptr;
    logic [CntW-1:0]       r_count;
    logic [SyncStages-1:0] r_sck_sync;
    logic [SyncStages-1:0] r_csb_sync;
    logic                  r_sck_q;
    logic                  r_csb_q;
    logic [0:0]            r_state;
    logic [7:0]            r_shift;
    logic [2:0]            r_bitcnt;
    logic                  r_sdo_en;
    logic                  r_byte_done;
    logic                  r_underflow;

    logic w_sck;
    logic w_csb;
    logic w_csb_fall;
    logic w_csb_rise;
    logic w_sck_fall;
    logic w_empty;
    logic w_load;
    logic w_push;
    logic w_pop;

    assign w_sck      = r_sck_sync[SyncStages-1];
    assign w_csb      = r_csb_sync[SyncStages-1];
    assign w_csb_fall = r_csb_q & ~w_csb;
    assign w_csb_rise = ~r_csb_q & w_csb;
    assign w_sck_fall = r_sck_q & ~w_sck;

    assign w_empty    = (r_count == '0);
    assign tx_ready_o = (r_count != FullCount);
    // A new byte enters the shifter at frame start and after every completed byte.
    assign w_load     = ((r_state == StIdle) && w_csb_fall) ||
                        ((r_state == StShift) && !w_csb_rise && w_sck_fall && (r_bitcnt == 3'd7));
    assign w_pop      = w_load && !w_empty;
    assign w_push     = tx_valid_i && tx_ready_o && !flush_i;

    assign fifo_depth_o  = r_count;
    assign sdo_o         = r_shift[7];
    assign sdo_en_o      = r_sdo_en;
    assign byte_done_o   = r_byte_done;
    assign txunderflow_o = r_underflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sck_sync <= '0;
            r_csb_sync <= '1;
            r_sck_q    <= 1'b0;
            r_csb_q    <= 1'b1;
        end else begin
            r_sck_sync <= SyncStages'({r_sck_sync, sck_i});
            r_csb_sync <= SyncStages'({r_csb_sync, csb_i});
            r_sck_q    <= w_sck;
            r_csb_q    <= w_csb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_sdo_en    <= 1'b0;
            r_byte_done <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_underflow <= 1'b0;
            if (r_state == StIdle) begin
                if (w_csb_fall) begin
                    r_state  <= StShift;
                    r_sdo_en <= 1'b1;
                    r_bitcnt <= 3'd0;
                end
            end else begin
                // CSB rise wins over a coincident SCK fall; the partial byte is dropped.
                if (w_csb_rise) begin
                    r_state  <= StIdle;
                    r_sdo_en <= 1'b0;
                    r_bitcnt <= 3'd0;
                end else if (w_sck_fall) begin
                    if (r_bitcnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                        r_bitcnt    <= 3'd0;
                    end else begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end
            end
            if (w_load) begin
                if (w_empty) begin
                    r_shift     <= DefaultByte;
                    r_underflow <= 1'b1;
                end else begin
                    r_shift <= r_mem[r_rptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_device_tx_serializer.sv
// Bench for spi_device_tx_serializer: a byte scoreboard fed by pushes and drained
// by SPI frames, a table of frame vectors, and hand sequences for FIFO/reset corners.
`timescale 1ns/1ps
module tb_spi_device_tx_serializer;

    localparam int         FIFO_D = 8;
    localparam logic [7:0] DEF    = 8'hFF;
    localparam int         HALF   = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       flush_i;
    logic [3:0] fifo_depth_o;
    logic       sck_i;
    logic       csb_i;
    logic       sdo_o;
    logic       sdo_en_o;
    logic       byte_done_o;
    logic       txunderflow_o;

    spi_device_tx_serializer #(
        .FifoDepth  (FIFO_D),
        .DefaultByte(DEF),
        .SyncStages (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .flush_i      (flush_i),
        .fifo_depth_o (fifo_depth_o),
        .sck_i        (sck_i),
        .csb_i        (csb_i),
        .sdo_o        (sdo_o),
        .sdo_en_o     (sdo_en_o),
        .byte_done_o  (byte_done_o),
        .txunderflow_o(txunderflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_uf     = 0;
    logic [7:0] sb[$];

    always @(posedge clk_i) begin
        if (byte_done_o)   n_done <= n_done + 1;
        if (txunderflow_o) n_uf   <= n_uf + 1;
    end

    typedef struct {
        int         npush;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nsck;
        int         exp_uf;
        int         exp_done;
        int         exp_depth;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        if (sb.size() < FIFO_D) sb.push_back(d);
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        chk("push_ready", tx_ready_o, sb.size() < FIFO_D);
        chk("push_depth", fifo_depth_o, sb.size());
    endtask

    task automatic sck_cycle();
        sck_i = 1'b1;
        wait_clk(HALF);
        sck_i = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic next_expect(output logic [7:0] b, inout int uf);
        if (sb.size() > 0) begin
            b = sb.pop_front();
        end else begin
            b = DEF;
            uf++;
        end
    endtask

    // One CSB-low frame of nsck SCK cycles; the host samples SDO on each SCK rise.
    task automatic run_frame(input int nsck, output int uf_got, output int done_got);
        logic [7:0] exp_b;
        logic [7:0] got;
        int         nbits;
        int         exp_uf;
        int         exp_done;
        int         uf0;
        int         done0;
        uf0 = n_uf; done0 = n_done; exp_uf = 0; exp_done = 0;
        next_expect(exp_b, exp_uf);
        csb_i = 1'b0;
        wait_clk(HALF);
        got = 8'h00; nbits = 0;
        for (int i = 0; i < nsck; i++) begin
            if (i == 0) chk("frame_sdo_en", sdo_en_o, 1'b1);
            got = {got[6:0], sdo_o};
            sck_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b0;
            wait_clk(HALF);
            nbits++;
            if (nbits == 8) begin
                chk("frame_byte", got, exp_b);
                exp_done++;
                next_expect(exp_b, exp_uf);
                got = 8'h00; nbits = 0;
            end
        end
        csb_i = 1'b1;
        wait_clk(HALF);
        if (nbits != 0) chk("frame_partial", got, exp_b >> (8 - nbits));
        chk("frame_sdo_en_off", sdo_en_o, 1'b0);
        uf_got   = n_uf - uf0;
        done_got = n_done - done0;
        chk("frame_uf_model", uf_got, exp_uf);
        chk("frame_done_model", done_got, exp_done);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int uf_g, done_g, uf0, done0;
        vecs[0] = '{2, 8'hA5, 8'h3C, 16, 1, 2, 0};
        vecs[1] = '{0, 8'h00, 8'h00, 8,  2, 1, 0};
        vecs[2] = '{2, 8'h81, 8'h7E, 4,  0, 0, 1};
        vecs[3] = '{0, 8'h00, 8'h00, 8,  1, 1, 0};
        vecs[4] = '{1, 8'h00, 8'h00, 8,  1, 1, 0};
        vecs[5] = '{2, 8'h5A, 8'hC3, 12, 0, 1, 0};

        rst_ni = 1'b0; tx_data_i = 8'h00; tx_valid_i = 1'b0; flush_i = 1'b0;
        sck_i = 1'b0; csb_i = 1'b1;
        wait_clk(3);
        chk("rst_ready", tx_ready_o, 1'b1);
        chk("rst_depth", fifo_depth_o, 0);
        chk("rst_sdo", sdo_o, 1'b0);
        chk("rst_sdo_en", sdo_en_o, 1'b0);
        chk("rst_done", byte_done_o, 1'b0);
        chk("rst_uf", txunderflow_o, 1'b0);
        rst_ni = 1'b1;
        wait_clk(4);
        chk("post_rst_depth", fifo_depth_o, 0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].npush > 0) push_byte(vecs[v].d0);
            if (vecs[v].npush > 1) push_byte(vecs[v].d1);
            wait_clk(2);
            run_frame(vecs[v].nsck, uf_g, done_g);
            chk($sformatf("vec%0d_uf", v), uf_g, vecs[v].exp_uf);
            chk($sformatf("vec%0d_done", v), done_g, vecs[v].exp_done);
            chk($sformatf("vec%0d_depth", v), fifo_depth_o, vecs[v].exp_depth);
        end

        // Overfill: ninth back-to-back push is dropped.
        for (int k = 0; k < FIFO_D + 1; k++) push_byte(8'h10 + 8'(k));
        chk("full_ready", tx_ready_o, 1'b0);
        chk("full_depth", fifo_depth_o, FIFO_D);

        // Flush beats a same-cycle push.
        tx_data_i = 8'hAA; tx_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0; flush_i = 1'b0;
        sb.delete();
        chk("flush_depth", fifo_depth_o, 0);
        chk("flush_ready", tx_ready_o, 1'b1);

        // Refill past full and drain: the dropped byte must never appear.
        for (int k = 0; k < FIFO_D + 1; k++) push_byte(8'h40 + 8'(k));
        run_frame(8 * FIFO_D, uf_g, done_g);
        chk("drain_uf", uf_g, 1);
        chk("drain_done", done_g, FIFO_D);
        chk("drain_depth", fifo_depth_o, 0);

        // SCK toggling with CSB high must not advance anything.
        push_byte(8'h96);
        uf0 = n_uf; done0 = n_done;
        repeat (4) sck_cycle();
        chk("csbhi_depth", fifo_depth_o, 1);
        chk("csbhi_sdo_en", sdo_en_o, 1'b0);
        chk("csbhi_pulses", (n_uf - uf0) + (n_done - done0), 0);
        run_frame(8, uf_g, done_g);
        chk("csbhi_frame_uf", uf_g, 1);

        // Reset during bit 3 of a byte.
        push_byte(8'h11);
        push_byte(8'h22);
        csb_i = 1'b0;
        wait_clk(HALF);
        repeat (3) sck_cycle();
        chk("pre_rst_sdo_en", sdo_en_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_sdo", sdo_o, 1'b0);
        chk("midrst_sdo_en", sdo_en_o, 1'b0);
        chk("midrst_ready", tx_ready_o, 1'b1);
        chk("midrst_depth", fifo_depth_o, 0);
        chk("midrst_done", byte_done_o, 1'b0);
        chk("midrst_uf", txunderflow_o, 1'b0);
        wait_clk(2);
        csb_i = 1'b1; sck_i = 1'b0;
        rst_ni = 1'b1;
        sb.delete();
        wait_clk(4);
        chk("rel_depth", fifo_depth_o, 0);
        chk("rel_sdo_en", sdo_en_o, 1'b0);
        run_frame(8, uf_g, done_g);
        chk("rel_frame_uf", uf_g, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
